// File: rtl/wmem_pkg.sv
// Shared state type and elaboration helpers for the weight_bank_stream slice.
package wmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } wmem_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wmem_bank.sv
// One weight bank: simple dual-port block RAM, read-first, registered read output.
module wmem_bank #(
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register resets so the streamed word reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n)  rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/weight_bank_stream.sv
// NUM_CH weight banks loaded sequentially, streamed in lock-step with valid/ready.
// Optional extra output stage: define WMEM_OUT_REG_EN (read latency 2 instead of 1).
//   state  | meaning
//   IDLE   | loads accepted, waiting for start
//   STREAM | issuing reads at raddr 0..DEPTH-1
//   DRAIN  | all reads issued, waiting for the out_last handshake
module weight_bank_stream
    import wmem_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_clr,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [CH_W-1:0]          ld_ch,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [NUM_CH*DATA_W-1:0] wout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (NUM_CH < 1 || DEPTH < 2 || ADDR_W < clog2(DEPTH) || CH_W < clog2(NUM_CH)) begin : g_bad_params
        $error("weight_bank_stream: inconsistent parameters");
    end

    wmem_state_e state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] wptr_q [NUM_CH];
    logic [ADDR_W-1:0] wptr_d [NUM_CH];
    logic ld_ready_q, ld_ready_d;
    logic done_q, done_d;
    logic vld1_q, vld1_d;
    logic last1_q, last1_d;
    logic [NUM_CH*DATA_W-1:0] rdata;
    logic adv, rd_en, ld_fire, last_hs;

    // Global stall: every pipeline stage moves only when the output slot frees.
    assign adv     = out_ready | ~out_valid;
    assign rd_en   = adv & (state_q == STREAM);
    assign ld_fire = ld_valid & ld_ready_q;
    assign last_hs = (state_q == DRAIN) & out_valid & out_ready & out_last;

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    raddr_d = '0;
                end
            end
            STREAM: begin
                if (adv) begin
                    raddr_d = raddr_q + 1'b1;
                    if (raddr_q == LAST_ADDR) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ld_ready_d = (state_d == IDLE);

        vld1_d  = vld1_q;
        last1_d = last1_q;
        if (adv) begin
            vld1_d  = (state_q == STREAM);
            last1_d = (state_q == STREAM) && (raddr_q == LAST_ADDR);
        end

        // A clear beats a simultaneous load; the word still lands at the old pointer.
        for (int k = 0; k < NUM_CH; k++) begin
            wptr_d[k] = wptr_q[k];
            if (ld_fire && (int'(ld_ch) == k))
                wptr_d[k] = (wptr_q[k] == LAST_ADDR) ? '0 : wptr_q[k] + 1'b1;
            if (ld_clr) wptr_d[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            raddr_q    <= '0;
            ld_ready_q <= 1'b0;
            done_q     <= 1'b0;
            vld1_q     <= 1'b0;
            last1_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) wptr_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            ld_ready_q <= ld_ready_d;
            done_q     <= done_d;
            vld1_q     <= vld1_d;
            last1_q    <= last1_d;
            for (int k = 0; k < NUM_CH; k++) wptr_q[k] <= wptr_d[k];
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_bank
        wmem_bank #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (ld_fire && (int'(ld_ch) == k)),
            .waddr (wptr_q[k]),
            .wdata (ld_data),
            .re    (rd_en),
            .raddr (raddr_q),
            .rdata (rdata[k*DATA_W +: DATA_W])
        );
    end

`ifdef WMEM_OUT_REG_EN
    logic vld2_q, vld2_d;
    logic last2_q, last2_d;
    logic [NUM_CH*DATA_W-1:0] wout_q, wout_d;

    always_comb begin
        vld2_d  = vld2_q;
        last2_d = last2_q;
        wout_d  = wout_q;
        if (adv) begin
            vld2_d  = vld1_q;
            last2_d = last1_q;
            wout_d  = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld2_q  <= 1'b0;
            last2_q <= 1'b0;
            wout_q  <= '0;
        end else begin
            vld2_q  <= vld2_d;
            last2_q <= last2_d;
            wout_q  <= wout_d;
        end
    end

    assign out_valid = vld2_q;
    assign out_last  = last2_q;
    assign wout      = wout_q;
`else
    assign out_valid = vld1_q;
    assign out_last  = last1_q;
    assign wout      = rdata;
`endif

    assign ld_ready = ld_ready_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_weight_bank_stream.sv
// Directed bench for weight_bank_stream: load, stream, back-pressure, abort, wrap/clear.
module tb_weight_bank_stream;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 784;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int CH_W   = 3;
`ifdef WMEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ld_clr = 1'b0;
    logic ld_valid = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [CH_W-1:0] ld_ch = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic ld_ready, busy, done, out_valid, out_last;
    logic [NUM_CH*DATA_W-1:0] wout;

    weight_bank_stream #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_clr    (ld_clr),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_ch     (ld_ch),
        .ld_data   (ld_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .wout      (wout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int refused = 0;
    logic [DATA_W-1:0] model [NUM_CH][DEPTH];
    int wptr_m [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] snap [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected contents track only what a correct design should accept in IDLE.
    task automatic load_word(input int ch, input logic [DATA_W-1:0] data, input bit clr);
        ld_valid = 1'b1;
        ld_ch    = CH_W'(ch);
        ld_data  = data;
        ld_clr   = clr;
        if (!ld_ready) refused++;
        step();
        ld_valid = 1'b0;
        ld_clr   = 1'b0;
        if (ch < NUM_CH) begin
            model[ch][wptr_m[ch]] = data;
            wptr_m[ch] = (wptr_m[ch] + 1) % DEPTH;
        end
        if (clr) for (int k = 0; k < NUM_CH; k++) wptr_m[k] = 0;
    endtask

    // mode 0: ready high; 1: ready toggles; 2: load/start during stream; 3: reset at beat 100
    task automatic run_stream(input int mode, input string tag);
        int beat, cyc, first_valid, data_errs, last_errs, stall_errs, early_done, extra, idle_bad;
        bit fin, prev_stall, prev_last;
        logic [NUM_CH*DATA_W-1:0] prev_w;
        logic [6:0] pat;
        pat = 7'b1001101;
        beat = 0; cyc = 0; first_valid = -1;
        data_errs = 0; last_errs = 0; stall_errs = 0; early_done = 0; extra = 0; idle_bad = 0;
        fin = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_w = '0;
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        else passed++;
        while (!fin && cyc < 20000 && beat < DEPTH + 4) begin
            if (mode == 3 && beat == 100) begin
                rst_n = 1'b0;
                out_ready = 1'b1;
                step();
                rst_n = 1'b1;
                checks++;
                if ({busy, done, out_valid, out_last, ld_ready} !== 5'b0 || wout !== '0)
                    $display("FAIL %s abort_outputs: got b/d/v/l/r=%b wout=%h want 0", tag,
                             {busy, done, out_valid, out_last, ld_ready}, wout);
                else passed++;
                for (int i = 0; i < 6; i++) begin
                    step();
                    if (done || busy || out_valid) early_done++;
                end
                checks++;
                if (early_done !== 0) $display("FAIL %s abort_quiet: got %0d active cycles want 0", tag, early_done);
                else passed++;
                for (int k = 0; k < NUM_CH; k++) wptr_m[k] = 0;
                return;
            end
            out_ready = (mode == 1) ? pat[cyc % 7] : 1'b1;
            if (mode == 2 && cyc == 10) begin
                ld_valid = 1'b1;
                ld_ch    = '0;
                ld_data  = 16'hDEAD;
                start    = 1'b1;
                checks++;
                if (ld_ready !== 1'b0) $display("FAIL %s ld_ready_in_stream: got %b want 0", tag, ld_ready);
                else passed++;
            end
            if (prev_stall && (!out_valid || wout !== prev_w || out_last !== prev_last)) stall_errs++;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (beat >= DEPTH) extra++;
                else begin
                    for (int k = 0; k < NUM_CH; k++)
                        if (wout[k*DATA_W +: DATA_W] !== model[k][beat]) begin
                            if (data_errs == 0)
                                $display("FAIL %s beat_data: beat %0d bank %0d got %h want %h", tag, beat, k,
                                         wout[k*DATA_W +: DATA_W], model[k][beat]);
                            data_errs++;
                        end
                    if (out_last !== (beat == DEPTH - 1)) last_errs++;
                    if (beat < 3) snap[beat] = wout;
                    if (beat == DEPTH - 1) snap[3] = wout;
                end
                if (out_ready) begin
                    if (out_last) fin = 1'b1;
                    beat++;
                end
            end
            if (done) early_done++;
            prev_stall = out_valid & ~out_ready;
            prev_w     = wout;
            prev_last  = out_last;
            step();
            cyc++;
            ld_valid = 1'b0;
            start    = 1'b0;
        end
        checks++;
        if (fin !== 1'b1) $display("FAIL %s stream_end: got no out_last handshake want one", tag);
        else passed++;
        checks++;
        if (beat !== DEPTH) $display("FAIL %s beat_count: got %0d want %0d", tag, beat, DEPTH);
        else passed++;
        checks++;
        if (data_errs + extra !== 0) $display("FAIL %s data_errs: got %0d want 0", tag, data_errs + extra);
        else passed++;
        checks++;
        if (last_errs !== 0) $display("FAIL %s out_last_pos: got %0d misplaced want 0", tag, last_errs);
        else passed++;
        checks++;
        if (stall_errs !== 0) $display("FAIL %s stall_stable: got %0d changes want 0", tag, stall_errs);
        else passed++;
        checks++;
        if (first_valid !== LAT) $display("FAIL %s first_valid_lat: got %0d want %0d", tag, first_valid, LAT);
        else passed++;
        checks++;
        if (early_done !== 0) $display("FAIL %s early_done: got %0d want 0", tag, early_done);
        else passed++;
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL %s done_pulse: got done/busy=%b want 10", tag, {done, busy});
        else passed++;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || busy || out_valid) idle_bad++;
        end
        checks++;
        if (idle_bad !== 0) $display("FAIL %s after_done_idle: got %0d active cycles want 0", tag, idle_bad);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({busy, done, out_valid, out_last, ld_ready} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {busy, done, out_valid, out_last, ld_ready});
        else passed++;
        checks++;
        if (wout !== '0) $display("FAIL reset_wout: got %h want 0", wout);
        else passed++;
        rst_n = 1'b1;
        step();
        checks++;
        if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b want 1", ld_ready);
        else passed++;
    endtask

    task automatic test_load_all();
        refused = 0;
        for (int k = 0; k < NUM_CH; k++)
            for (int a = 0; a < DEPTH; a++)
                load_word(k, DATA_W'((k << 12) + a), 1'b0);
        checks++;
        if (refused !== 0) $display("FAIL load_refused: got %0d want 0", refused);
        else passed++;
    endtask

    task automatic test_stream_basic();
        run_stream(0, "basic");
        checks++;
        if (snap[3] !== 64'h330F_230F_130F_030F) $display("FAIL basic_last_word: got %h want 330f230f130f030f", snap[3]);
        else passed++;
    endtask

    task automatic test_back_pressure();
        run_stream(1, "backpressure");
    endtask

    task automatic test_busy_interference();
        run_stream(2, "interfere");
        run_stream(0, "after_interfere");
        checks++;
        if (snap[0] !== 64'h3000_2000_1000_0000) $display("FAIL interfere_beat0: got %h want 3000200010000000", snap[0]);
        else passed++;
    endtask

    task automatic test_abort();
        run_stream(3, "abort");
        step();
        run_stream(0, "after_abort");
    endtask

    task automatic test_wrap_clear();
        refused = 0;
        for (int a = 0; a < DEPTH + 2; a++) load_word(1, DATA_W'(16'h8000 + a), 1'b0);
        load_word(1, 16'h7777, 1'b1);
        load_word(1, 16'hABCD, 1'b0);
        load_word(7, 16'h5555, 1'b0);
        checks++;
        if (refused !== 0) $display("FAIL wrap_refused: got %0d want 0", refused);
        else passed++;
        run_stream(0, "wrap");
        checks++;
        if (snap[0][DATA_W +: DATA_W] !== 16'hABCD) $display("FAIL wrap_addr0: got %h want abcd", snap[0][DATA_W +: DATA_W]);
        else passed++;
        checks++;
        if (snap[1][DATA_W +: DATA_W] !== 16'h8311) $display("FAIL wrap_addr1: got %h want 8311", snap[1][DATA_W +: DATA_W]);
        else passed++;
        checks++;
        if (snap[2][DATA_W +: DATA_W] !== 16'h7777) $display("FAIL clr_old_ptr: got %h want 7777", snap[2][DATA_W +: DATA_W]);
        else passed++;
        checks++;
        if (snap[3][DATA_W +: DATA_W] !== 16'h830F) $display("FAIL wrap_last: got %h want 830f", snap[3][DATA_W +: DATA_W]);
        else passed++;
        checks++;
        if (snap[0][0 +: DATA_W] !== 16'h0000 || snap[0][3*DATA_W +: DATA_W] !== 16'h3000)
            $display("FAIL bad_ch_discard: got %h want 3000xxxxxxxx0000 with banks 0/3 untouched", snap[0]);
        else passed++;
    endtask

    initial begin
        for (int k = 0; k < NUM_CH; k++) wptr_m[k] = 0;
        test_reset();
        test_load_all();
        test_stream_basic();
        test_back_pressure();
        test_busy_interference();
        test_abort();
        test_wrap_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
